// File: rtl/program_counter.sv
// program_counter: fetch-stage PC register for an RV32 pipeline.
// Holds the current instruction address and offers its sequential
// successor combinationally. Each rising edge loads either the
// sequential address or an ALU branch/jump target.
module program_counter #(
  parameter int unsigned            XLEN         = 32,
  parameter logic [XLEN-1:0]        RESET_VECTOR = 32'h0000_0000,
  parameter int unsigned            INC          = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            sel_pc,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_alu,
  output logic [XLEN-1:0] pc_nxt,
  output logic [XLEN-1:0] pc
);

  // Increment sized to the address width so the add wraps modulo 2^XLEN.
  localparam logic [XLEN-1:0] INC_W = XLEN'(INC);

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pc_d;

  // Jump/branch targets never carry bit 0 (JALR rule); bit 1 is kept so
  // misalignment can still be detected downstream.
  function automatic logic [XLEN-1:0] clear_lsb(input logic [XLEN-1:0] addr);
    logic [XLEN-1:0] res;
    res      = addr;
    res[0]   = 1'b0;
    return res;
  endfunction

  // Next-PC select: ALU target when sel_pc is high, else the sequential address.
  always_comb begin
    pc_d = pc_q;
    if (sel_pc) begin
      pc_d = clear_lsb(in_alu);
    end else begin
      pc_d = in_pc;
    end
  end

  // PC register with synchronous reset that overrides any select.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_VECTOR;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc     = pc_q;
  // Successor follows pc with no added latency.
  assign pc_nxt = pc_q + INC_W;

endmodule

// File: tb/tb_program_counter.sv
// Directed self-checking bench for program_counter.
module tb_program_counter;

  logic        clk;
  logic        rst;
  logic        sel_pc;
  logic [31:0] in_pc;
  logic [31:0] in_alu;
  logic [31:0] pc_nxt;
  logic [31:0] pc;

  logic        loop_en;
  logic [31:0] in_pc_drv;

  int checks;
  int errors;

  // Sequential address is either pc_nxt looped back or a bench-driven value.
  assign in_pc = loop_en ? pc_nxt : in_pc_drv;

  program_counter #(
    .XLEN         (32),
    .RESET_VECTOR (32'h0000_0000),
    .INC          (4)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .sel_pc (sel_pc),
    .in_pc  (in_pc),
    .in_alu (in_alu),
    .pc_nxt (pc_nxt),
    .pc     (pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Check pc and pc_nxt together.
  task automatic check_pc(input string tag, input logic [31:0] exp_pc);
    check_eq({tag, "_pc"}, pc, exp_pc);
    check_eq({tag, "_nxt"}, pc_nxt, exp_pc + 32'd4);
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    loop_en   = 1'b1;
    in_pc_drv = 32'h0000_0000;
    rst       = 1'b1;
    sel_pc    = 1'b1;
    in_alu    = 32'h0000_8000;

    // Reset overrides a simultaneous jump.
    step();
    check_pc("reset", 32'h0000_0000);

    // Sequential fetch.
    rst    = 1'b0;
    sel_pc = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      step();
      check_pc($sformatf("seq%0d", k), 32'(k * 4));
    end

    // Jump held for two edges, then release.
    sel_pc = 1'b1;
    in_alu = 32'h0000_8000;
    step();
    check_pc("jump", 32'h0000_8000);
    step();
    check_pc("jump_hold", 32'h0000_8000);
    sel_pc = 1'b0;
    step();
    check_pc("post_jump1", 32'h0000_8004);
    step();
    check_pc("post_jump2", 32'h0000_8008);

    // JALR LSB clear; bit 1 passes through.
    sel_pc = 1'b1;
    in_alu = 32'h0000_1235;
    step();
    check_eq("jalr_lsb", pc, 32'h0000_1234);
    in_alu = 32'h0000_1237;
    step();
    check_eq("jalr_bit1", pc, 32'h0000_1236);

    // Sequential path is not masked; external hold works.
    sel_pc    = 1'b0;
    loop_en   = 1'b0;
    in_pc_drv = 32'h0000_0103;
    step();
    check_eq("in_pc_raw", pc, 32'h0000_0103);
    in_pc_drv = 32'h0000_0100;
    step();
    step();
    check_eq("hold", pc, 32'h0000_0100);
    loop_en = 1'b1;

    // Wrap-around.
    sel_pc = 1'b1;
    in_alu = 32'hFFFF_FFFC;
    step();
    check_eq("wrap_pc", pc, 32'hFFFF_FFFC);
    check_eq("wrap_nxt", pc_nxt, 32'h0000_0000);
    sel_pc = 1'b0;
    step();
    check_pc("wrap_after", 32'h0000_0000);

    // Reset mid-run while sequencing at 0x8010.
    sel_pc = 1'b1;
    in_alu = 32'h0000_8010;
    step();
    check_eq("pre_rst", pc, 32'h0000_8010);
    sel_pc = 1'b0;
    rst    = 1'b1;
    step();
    check_pc("mid_rst", 32'h0000_0000);
    rst = 1'b0;
    step();
    check_pc("resume", 32'h0000_0004);

    // Reset pulse between edges has no effect.
    #2 rst = 1'b1;
    #1 rst = 1'b0;
    step();
    check_pc("glitch_rst", 32'h0000_0008);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/program_counter.md
# program_counter

Program counter register for the RV32 pipeline's fetch stage. It holds the current instruction address `pc` and combinationally produces the sequential successor `pc_nxt = pc + 4`. On each clock it loads either the externally supplied sequential address `in_pc` or the ALU-computed target `in_alu` (branch/jump), selected by `sel_pc`. In the pipeline, `pc_nxt` is normally looped back into `in_pc` at the top level.

## Interface
- `XLEN`, 32: address width in bits.
- `RESET_VECTOR`, 32'h0000_0000: value loaded into `pc` on reset.
- `INC`, 4: sequential increment (bytes per instruction).

- `clk`  input  1  system clock; all state updates on the rising edge.
- `rst`  input  1  one clock; reset is synchronous and active-high.
- `sel_pc`  input  1  next-PC select: 0 = `in_pc`, 1 = `in_alu`.
- `in_pc`  input  XLEN  sequential next address, normally `pc_nxt` fed back.
- `in_alu`  input  XLEN  branch/jump target from the ALU.
- `pc_nxt`  output  XLEN  combinational `pc + INC`.
- `pc`  output  XLEN  registered current PC.

## Operation
- State is one XLEN-bit register `pc`.
- `pc_nxt` is purely combinational: `pc_nxt = pc + INC`, modulo 2^XLEN. It updates in the same cycle `pc` changes.
- Next-state priority, evaluated at each rising `clk`:
  1. `rst` = 1: `pc` <= `RESET_VECTOR`. `sel_pc`, `in_pc` and `in_alu` are ignored.
  2. `sel_pc` = 1: `pc` <= `in_alu` with bit 0 forced to 0, per RV32 JALR target rule. Bit 1 passes through unchanged.
  3. `sel_pc` = 0: `pc` <= `in_pc`, unmodified.
- No alignment trap is generated. Misaligned-target detection belongs to other logic.
- No stall or enable input: `pc` updates every cycle. Holding the PC is done by driving `in_pc` = `pc` externally.
- Power-up value before the first reset is undefined. The bench must not check `pc` or `pc_nxt` until one reset edge has occurred.

## Timing
- Latency: `in_pc`/`in_alu`/`sel_pc` sampled at edge N appear on `pc` immediately after edge N (one register stage). `pc_nxt` follows `pc` with zero cycles of latency.
- Reset: `rst` must be high at a rising edge to take effect. An asynchronous `rst` pulse that contains no rising edge has no effect.
- After reset: `pc` = `RESET_VECTOR`, `pc_nxt` = `RESET_VECTOR + 4`.
- Reset mid-operation: reset overrides a simultaneous `sel_pc` = 1 on the same edge.
- `sel_pc` held high: `pc` reloads `in_alu` every edge. With a constant `in_alu`, `pc` stays constant.
- Wrap-around: `pc` = 32'hFFFF_FFFC gives `pc_nxt` = 32'h0000_0000, with no flag.
- No handshakes. All inputs must be stable around each rising edge.

## Test plan
- Reset: hold `rst` = 1 across one rising edge with `sel_pc` = 1 and `in_alu` = 32'h8000 -> `pc` = 0, `pc_nxt` = 4.
- Sequential fetch: loop `pc_nxt` into `in_pc`, `sel_pc` = 0, deassert reset, run 5 edges -> `pc` = 4, 8, 12, 16, 20 on successive edges; `pc_nxt` = `pc` + 4 at all times.
- Jump: from `pc` = 20, set `sel_pc` = 1 with `in_alu` = 32'h0000_8000 -> `pc` = 32'h8000 after the next edge and stays 32'h8000 while `sel_pc` is held; `pc_nxt` = 32'h8004. Release `sel_pc` -> `pc` = 32'h8004, then 32'h8008.
- JALR LSB clear: `sel_pc` = 1, `in_alu` = 32'h0000_1235 -> `pc` = 32'h0000_1234.
- Wrap: drive `in_alu` = 32'hFFFF_FFFC with `sel_pc` = 1 for one edge, then loop back -> `pc_nxt` = 0 while `pc` = 32'hFFFF_FFFC, then `pc` = 0 on the next edge.
- Reset mid-run: assert `rst` for one edge while sequencing at `pc` = 32'h8010 -> `pc` = 0 on that edge; sequencing resumes at 4 on the following edge.
